vec_elem_seq: RTL
=================

// Module: vec_elem_seq
// PURPOSE
// Element sequencer directly downstream of the vector-length register.
// Each accepted vector instruction snapshots the current VL and emits beats of
// LANES element indices, with a tail mask, to the lane datapath over valid/ready.
// It then pulses done. Runs on the vector unit clock, next to the VL register.
// PARAMETERS
// MVL    16  maximum vector length in elements; power of two; multiple of LANES
// LANES  2   elements per beat; power of two, 1..MVL
// IDW    4   width of the instruction tag carried through
// PORTS  (VLW = $clog2(MVL)+1, IW = $clog2(MVL), with a minimum of 1)
// clk         in   1      clock; all state changes on posedge
// rst         in   1      synchronous, active-high reset
// vlr         in   VLW    current VL, taken from the VL register output
// start_valid in   1      instruction issue request
// start_ready out  1      sequencer can accept an instruction
// start_id    in   IDW    tag of the issued instruction
// kill        in   1      abort the in-flight instruction (flush)
// elem_valid  out  1      a beat is presented
// elem_ready  in   1      the lane datapath accepts the beat
// elem_idx    out  IW     index of the beat's first element (lane 0)
// elem_mask   out  LANES  bit i set when element elem_idx+i < VL
// elem_last   out  1      final beat of the instruction
// elem_id     out  IDW    tag of the in-flight instruction
// done_valid  out  1      one-cycle completion pulse
// done_id     out  IDW    tag of the completed instruction
// busy        out  1      state != IDLE
// BEHAVIOUR
// - Reset (synchronous, priority over all else): state=IDLE; counters, regs, tags = 0.
//   All outputs 0 except start_ready=1 (IDLE, kill low).
// - FSM IDLE/RUN/DONE. start_ready = (state==IDLE) & ~kill.
//   Fire = valid & ready.
// - IDLE, start fires: vl_q <= min(vlr, MVL) using a VLW-bit compare;
//   id_q <= start_id; cnt <= 0. Next state is RUN if vl_q != 0, else DONE.
// - Latency: start fires in cycle N -> elem_valid=1 and elem_idx=0 in cycle N+1.
// - RUN: elem_valid=1. On fire, cnt += LANES, computed VLW+1 bits wide, no wrap.
//   Throughput is 1 beat/cycle.
// - elem_last = (cnt + LANES >= vl_q). If elem_last fires: state goes to DONE.
// - While elem_valid & ~elem_ready: idx, mask, last and id hold stable.
//   elem_valid never drops without a fire, except on kill or rst.
// - elem_mask[i] = (cnt + i < vl_q). All ones except on a partial tail beat.
// - DONE: done_valid=1 and done_id=id_q for exactly one cycle, then IDLE.
//   No ready is needed. Next start is accepted at the earliest in the cycle after DONE.
// - vl_q is a snapshot. vlr changes after acceptance do not affect the in-flight op.
// - vlr=0: no beats are emitted; done pulses in cycle N+1.
// - vlr>MVL (e.g. 20 at MVL=16): clamped to MVL.
// - kill (any state): next state IDLE; elem_valid and done_valid are 0 next cycle.
//   A DONE pulse cycle is suppressed; no done is emitted for the killed op.
//   A kill in the same cycle as start_valid takes priority: start is not accepted.
// - elem_idx = cnt[IW-1:0]. Beats never reach cnt >= MVL, because of elem_last.
// STRUCTURE
// - Shared package vecunit_pkg holds: the bitwidth/log2 functions, the VLW and IW
//   derivation, the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//   and the MVL default.
// - One sub-module: vec_tail_mask (combinational; cnt, vl_q -> elem_mask, elem_last),
//   shared with future masked-op units.
// TESTING  (MVL=16, LANES=2 unless stated)
// 1 rst held 2 cycles mid-RUN -> next cycle busy=0, elem_valid=0, done_valid=0,
//   start_ready=1.
// 2 vlr=5, start id=3, elem_ready=1 -> beats idx 0/2/4, mask 11/11/01, last on idx 4;
//   done_valid with done_id=3 in the cycle after.
// 3 vlr=20, elem_ready toggling 1,0,0,1... -> 8 beats idx 0..14, mask 11, values stable
//   during stalls, done once.
// 4 vlr=0, start -> no elem_valid ever; done_valid in N+1; start_ready back in N+2.
// 5 vlr=8, start, then vlr=3 in the next cycle -> still 4 full beats (snapshot honoured).
// 6 kill on the 2nd beat of vl=8 -> elem_valid=0 next cycle, no done;
//   kill+start in the same cycle -> not accepted.

Source files
------------

// File: rtl/vecunit_pkg.sv
// rtl/vecunit_pkg.sv - shared vector-unit widths, FSM encoding and defaults
package vecunit_pkg;

    localparam int MVL_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Bits needed to hold the value n itself (not n distinct codes).
    function automatic int bitwidth(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int log2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int vl_width(input int mvl);
        return bitwidth(mvl);
    endfunction

    function automatic int idx_width(input int mvl);
        return log2_min1(mvl);
    endfunction

endpackage

// File: rtl/vec_elem_seq_if.sv
// rtl/vec_elem_seq_if.sv - issue, element-beat and completion handshakes of the sequencer
interface vec_elem_seq_if
    import vecunit_pkg::*;
#(
    parameter int MVL   = MVL_DEFAULT,
    parameter int LANES = 2,
    parameter int IDW   = 4
) ();
    localparam int IW = idx_width(MVL);

    logic             start_valid;
    logic             start_ready;
    logic [IDW-1:0]   start_id;

    logic             elem_valid;
    logic             elem_ready;
    logic [IW-1:0]    elem_idx;
    logic [LANES-1:0] elem_mask;
    logic             elem_last;
    logic [IDW-1:0]   elem_id;

    logic             done_valid;
    logic [IDW-1:0]   done_id;

    modport master (
        output start_valid, start_id, elem_ready,
        input  start_ready, elem_valid, elem_idx, elem_mask, elem_last, elem_id,
        input  done_valid, done_id
    );

    modport slave (
        input  start_valid, start_id, elem_ready,
        output start_ready, elem_valid, elem_idx, elem_mask, elem_last, elem_id,
        output done_valid, done_id
    );

endinterface

// File: rtl/vec_tail_mask.sv
// rtl/vec_tail_mask.sv - per-lane tail mask and last-beat flag for a beat starting at cnt
module vec_tail_mask #(
    parameter int LANES = 2,
    parameter int VLW   = 5
) (
    input  logic [VLW:0]     cnt_i,
    input  logic [VLW-1:0]   vl_i,
    output logic [LANES-1:0] mask_o,
    output logic             last_o
);
    localparam int CW = VLW + 1;

    // One extra bit so cnt+LANES past the tail never wraps below vl.
    logic [CW-1:0] vl_ext;
    assign vl_ext = {1'b0, vl_i};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign mask_o[i] = (cnt_i + CW'(i)) < vl_ext;
    end

    assign last_o = (cnt_i + CW'(LANES)) >= vl_ext;

endmodule

// File: rtl/vec_elem_seq.sv
// rtl/vec_elem_seq.sv - snapshots VL per instruction and emits masked LANES-wide element beats
module vec_elem_seq
    import vecunit_pkg::*;
#(
    parameter int MVL   = MVL_DEFAULT,
    parameter int LANES = 2,
    parameter int IDW   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [vl_width(MVL)-1:0] vlr,
    input  logic                     kill,
    output logic                     busy,
    vec_elem_seq_if.slave            bus
);
    localparam int VLW = vl_width(MVL);
    localparam int IW  = idx_width(MVL);
    localparam int CW  = VLW + 1;

    localparam logic [VLW-1:0] MVL_V   = VLW'(MVL);
    localparam logic [CW-1:0]  LANES_C = CW'(LANES);

    seq_state_e       state_q, state_d;
    logic [VLW-1:0]   vl_q, vl_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   id_q, id_d;

    logic [VLW-1:0]   vl_clamped;
    logic             in_run;
    logic             start_fire;
    logic             elem_fire;
    logic [LANES-1:0] tail_mask;
    logic             tail_last;

    assign vl_clamped = (vlr > MVL_V) ? MVL_V : vlr;
    assign in_run     = (state_q == ST_RUN);
    assign start_fire = bus.start_valid & bus.start_ready;
    assign elem_fire  = in_run & bus.elem_ready;

    vec_tail_mask #(
        .LANES (LANES),
        .VLW   (VLW)
    ) u_tail (
        .cnt_i  (cnt_q),
        .vl_i   (vl_q),
        .mask_o (tail_mask),
        .last_o (tail_last)
    );

    always_comb begin
        state_d = state_q;
        vl_d    = vl_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_fire) begin
                    vl_d    = vl_clamped;
                    id_d    = bus.start_id;
                    cnt_d   = '0;
                    state_d = (vl_clamped != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (elem_fire) begin
                    cnt_d = cnt_q + LANES_C;
                    if (tail_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Flush wins from any state, including a pending completion.
        if (kill) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vl_q    <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            vl_q    <= vl_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE) & ~kill;
    assign bus.elem_valid  = in_run;
    assign bus.elem_idx    = cnt_q[IW-1:0];
    assign bus.elem_mask   = in_run ? tail_mask : '0;
    assign bus.elem_last   = in_run & tail_last;
    assign bus.elem_id     = id_q;
    assign bus.done_valid  = (state_q == ST_DONE) & ~kill;
    assign bus.done_id     = id_q;
    assign busy            = (state_q != ST_IDLE);

endmodule
